// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants, decode FSM states and the key event record.
package ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_PAUSE = 8'hE1;

  // Keyboard status/response bytes that never form part of a key event.
  localparam int unsigned N_STATUS = 6;
  localparam logic [7:0] SC_STATUS [N_STATUS] = '{8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'h00, 8'hFF};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } state_t;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } key_evt_t;

  function automatic logic is_status(input logic [7:0] b);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < N_STATUS; i++) begin
      if (b == SC_STATUS[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Circular-buffer event FIFO; occupancy counter decides full/empty.
// A push while full is still accepted when a pop happens in the same cycle.
module ps2_evt_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               pop_data,
  output logic [$clog2(DEPTH):0]     cnt,
  output logic                       drop
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok;

  // Head reads as zero while empty so the outputs are defined after reset.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Payload storage; no reset needed since the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_evt_ctrl.sv
// PS/2 key event sequencer: resolves E0/F0 prefixes, skips E1 pause
// sequences and status bytes, and queues key events for the display side.
// Optional typematic-repeat suppression: define KEY_REPEAT_FILTER_EN.
module ps2_key_evt_ctrl
  import ps2_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    byte_in,
  input  logic                          byte_vld,
  output logic [7:0]                    evt_code,
  output logic                          evt_ext,
  output logic                          evt_brk,
  output logic                          evt_vld,
  input  logic                          evt_rdy,
  output logic                          ovf,
  input  logic                          ovf_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_t     state, state_nx;
  logic [2:0] skip_cnt, skip_nx;
  logic [TW-1:0] tmo_cnt;
  logic       emit;
  key_evt_t   emit_evt;
  logic       keep;
  logic       push_q;
  key_evt_t   push_evt;
  logic       pop;
  logic       drop;
  logic [9:0] head_raw;
  key_evt_t   head;

  // Prefix decode: next state, skip counter and the event to emit.
  always_comb begin
    state_nx = state;
    skip_nx  = skip_cnt;
    emit     = 1'b0;
    emit_evt = '{ext: 1'b0, brk: 1'b0, code: byte_in};
    if (byte_vld) begin
      case (state)
        ST_IDLE: begin
          if (byte_in == SC_EXT) begin
            state_nx = ST_EXT;
          end else if (byte_in == SC_BRK) begin
            state_nx = ST_BRK;
          end else if (byte_in == SC_PAUSE) begin
            state_nx = ST_SKIP;
            skip_nx  = 3'd7;
          end else if (!is_status(byte_in)) begin
            emit = 1'b1;
          end
        end
        ST_EXT: begin
          if (byte_in == SC_BRK) begin
            state_nx = ST_EXT_BRK;
          end else begin
            emit         = 1'b1;
            emit_evt.ext = 1'b1;
            state_nx     = ST_IDLE;
          end
        end
        ST_BRK: begin
          emit         = 1'b1;
          emit_evt.brk = 1'b1;
          state_nx     = ST_IDLE;
        end
        ST_EXT_BRK: begin
          emit         = 1'b1;
          emit_evt.ext = 1'b1;
          emit_evt.brk = 1'b1;
          state_nx     = ST_IDLE;
        end
        ST_SKIP: begin
          if (skip_cnt <= 3'd1) begin
            skip_nx  = '0;
            state_nx = ST_IDLE;
          end else begin
            skip_nx = skip_cnt - 1'b1;
          end
        end
        default: state_nx = ST_IDLE;
      endcase
    end else if (state != ST_IDLE && tmo_cnt == TMO_LAST) begin
      // Abandon an unfinished sequence; a same-cycle byte takes priority above.
      state_nx = ST_IDLE;
      skip_nx  = '0;
    end
  end

`ifdef KEY_REPEAT_FILTER_EN
  logic [7:0] rec_code;
  logic       rec_ext;
  logic       rec_vld;
  logic       rec_hit;

  assign rec_hit = rec_vld && rec_code == emit_evt.code && rec_ext == emit_evt.ext;
  assign keep    = emit && !(rec_hit && !emit_evt.brk);

  // Last-pressed key record: set on a new make, cleared by its own break.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rec_code <= '0;
      rec_ext  <= 1'b0;
      rec_vld  <= 1'b0;
    end else if (emit) begin
      if (!emit_evt.brk && !rec_hit) begin
        rec_code <= emit_evt.code;
        rec_ext  <= emit_evt.ext;
        rec_vld  <= 1'b1;
      end else if (emit_evt.brk && rec_hit) begin
        rec_vld <= 1'b0;
      end
    end
  end
`else
  assign keep = emit;
`endif

  // FSM state, skip counter and idle timeout counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      skip_cnt <= '0;
      tmo_cnt  <= '0;
    end else begin
      state    <= state_nx;
      skip_cnt <= skip_nx;
      if (byte_vld || state == ST_IDLE) tmo_cnt <= '0;
      else                              tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Registered push stage: decode of byte N reaches the FIFO in cycle N+1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      push_q   <= 1'b0;
      push_evt <= '0;
    end else begin
      push_q   <= keep;
      push_evt <= emit_evt;
    end
  end

  assign pop = evt_vld && evt_rdy;

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (10)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_q),
    .push_data (push_evt),
    .pop       (pop),
    .pop_data  (head_raw),
    .cnt       (fifo_cnt),
    .drop      (drop)
  );

  assign head     = key_evt_t'(head_raw);
  assign evt_code = head.code;
  assign evt_ext  = head.ext;
  assign evt_brk  = head.brk;
  assign evt_vld  = (fifo_cnt != '0);

  // Sticky overflow flag; a new drop wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ovf <= 1'b0;
    else if (drop)    ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

endmodule
